// File: rtl/cb_drive_arbiter.sv
// Round-robin owner arbitration for the shared synchronous drive side of an interface.
// One owner drives b at a time, owners are separated by a one-cycle gap, and stalls time out.
module cb_drive_arbiter #(
   parameter int N       = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*DW-1:0]      req_data,
   input  logic [N-1:0]         req_last,
   output logic [N-1:0]         grant,
   output logic [DW-1:0]        b_data,
   output logic                 b_valid,
   input  logic                 a_ack,
   output logic                 err_timeout,
   output logic [$clog2(N)-1:0] err_id,
   output logic [15:0]          xfer_cnt
);

   localparam int IW = $clog2(N);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] owner, owner_nxt;
   logic [IW-1:0] rr_ptr, rr_ptr_nxt;
   logic [IW-1:0] err_id_nxt;
   logic [IW-1:0] win;
   logic          win_ok;
   logic [WW-1:0] wait_cnt, wait_cnt_nxt;
   logic          err_nxt;
   logic [15:0]   xfer_nxt;
   logic          accept;

   // Scan backwards so the requester closest to ptr is the last one written, i.e. the winner.
   function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (r[idx]) res = {1'b1, idx[IW-1:0]};
      end
      return res;
   endfunction

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] o);
      return (o == IW'(N - 1)) ? '0 : o + 1'b1;
   endfunction

   always_comb begin
      grant   = '0;
      b_valid = 1'b0;
      b_data  = '0;
      if (state == BUSY) begin
         grant[owner] = 1'b1;
         b_valid      = req[owner];
         if (req[owner]) b_data = req_data[int'(owner) * DW +: DW];
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      wait_cnt_nxt = '0;
      err_nxt      = 1'b0;
      err_id_nxt   = err_id;
      xfer_nxt     = xfer_cnt;
      {win_ok, win} = pick(req, rr_ptr);
      accept       = (state == BUSY) && req[owner] && a_ack;

      case (state)
         IDLE, GAP: begin
            if (win_ok) begin
               state_nxt = BUSY;
               owner_nxt = win;
            end else begin
               state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (accept) xfer_nxt = xfer_cnt + 16'd1;
            // Release priority: final beat accepted, then withdrawal, then stall timeout.
            if ((accept && req_last[owner]) || !req[owner]) begin
               state_nxt  = GAP;
               rr_ptr_nxt = next_idx(owner);
            end else if (!a_ack && (wait_cnt == WW'(TIMEOUT - 1))) begin
               state_nxt  = GAP;
               rr_ptr_nxt = next_idx(owner);
               err_nxt    = 1'b1;
               err_id_nxt = owner;
            end else if (!a_ack) begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         err_id      <= '0;
         xfer_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         rr_ptr      <= rr_ptr_nxt;
         wait_cnt    <= wait_cnt_nxt;
         err_timeout <= err_nxt;
         err_id      <= err_id_nxt;
         xfer_cnt    <= xfer_nxt;
      end
   end

endmodule

// File: doc/cb_drive_arbiter.md
# cb_drive_arbiter

Round-robin arbiter that shares the synchronous drive side of a testbench interface among N requesters. Each requester offers beats for the shared output `b`, and the interface input `a` acknowledges each beat. The block sits between the testbench agents and the interface's synchronous clocking-block modport. It guarantees a single driver at any time, a one-cycle turnaround between owners, and a bounded wait for acknowledge.

## Interface
- N, 4, number of requesters (2..16)
- DW, 8, beat data width
- TIMEOUT, 16, consecutive un-acknowledged valid cycles before forced release (≥1)

- clk  in  1  interface clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- req  in  N  per-requester request; held while requester has beats
- req_data  in  N*DW  beat data; slice i = req_data[i*DW +: DW]
- req_last  in  N  marks current beat of requester i as final
- grant  out  N  one-hot owner, zero when no owner
- b_data  out  DW  shared drive value (`b`)
- b_valid  out  1  beat valid on `b`
- a_ack  in  1  acknowledge from interface (`a`)
- err_timeout  out  1  one-cycle pulse on forced release
- err_id  out  $clog2(N)  owner index at last timeout (sticky until next timeout)
- xfer_cnt  out  16  total accepted beats, wraps 0xFFFF→0

## Operation
- States: IDLE, BUSY, GAP. The state register, owner, rr_ptr, wait_cnt, err and xfer_cnt are all registered.
- **Arbitration** (evaluated in IDLE and GAP):
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … mod N.
  - If a winner exists: owner←winner, next state BUSY. Otherwise IDLE.
- **BUSY outputs:**
  - grant = onehot(owner).
  - b_valid = req[owner].
  - b_data = req_data[owner slice] when b_valid=1, else 0.
- **Accept:** a beat is accepted on a posedge where b_valid=1 and a_ack=1. On each accept:
  - xfer_cnt increments.
  - wait_cnt←0.
- **Release**, taken on the first matching condition in priority order, always going BUSY→GAP:
  1. Accept with req_last[owner]=1.
  2. req[owner]=0 (requester withdrew; no beat counted).
  3. Timeout: b_valid=1, a_ack=0, and wait_cnt=TIMEOUT-1. This sets err_timeout=1 for the following cycle and err_id←owner.
- Stall handling: b_valid=1 and a_ack=0 without timeout gives wait_cnt+1. wait_cnt is 0 outside BUSY.
- On every release, rr_ptr←(owner+1) mod N.
- **GAP** is exactly one cycle:
  - grant=0, b_valid=0, b_data=0.
  - Arbitration runs here, so GAP goes directly to BUSY or IDLE.
- IDLE/GAP outputs: grant=0, b_valid=0, b_data=0.
- a_ack outside BUSY, or with b_valid=0, is ignored.
- Changes to req by non-owners never affect the current owner.
- **Reset values** (rst_n=0 at a posedge): state IDLE, owner 0, rr_ptr 0, wait_cnt 0, grant 0, b_valid 0, b_data 0, err_timeout 0, err_id 0, xfer_cnt 0.
  - Reset mid-BUSY drops ownership with no accept counted.
  - The cycle after reset deasserts follows normal IDLE rules.

## Timing
- Request-to-grant latency is 1 cycle: req rises before posedge k while IDLE, and grant/b_valid are high from edge k.
- Single-beat transfer with a_ack already high:
  - edge k: grant.
  - edge k+1: accept, enter GAP.
  - edge k+2: next owner's grant at the earliest.
- Back-to-back owners are always separated by exactly one GAP cycle (no overlap of grant bits).
- Timeout:
  - The owner is granted at edge k with a_ack held 0.
  - The release edge is k+TIMEOUT.
  - err_timeout is high for the single cycle after that edge.
- Outputs are combinational only from registered state/owner plus req/req_data of the owner. There is no path from a_ack to any output.

## Test plan
- **Reset:** drive random inputs with rst_n=0 for 3 cycles. All outputs must read 0. Release rst_n with req=0: outputs stay 0.
- **Round-robin, N=4:** req=4'b1111, each requester sends one beat with last=1, a_ack=1.
  - Grant sequence must be 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - xfer_cnt must read 4 after the fourth accept.
- **Burst with stalls:** requester 2 sends beats 0x11, 0x22, 0x33 (last on 0x33), with a_ack low for 2 cycles before each beat.
  - grant stays 0100 throughout.
  - b_data holds each value until accepted.
  - xfer_cnt+=3, no err_timeout.
- **Timeout, TIMEOUT=16:** requester 1 valid with a_ack=0.
  - Release occurs 16 cycles after the grant.
  - err_timeout is a single pulse, err_id=1.
  - The next grant goes to the requester after 1 in round-robin order.
- **Withdrawal and reset mid-burst:**
  - Owner 3 drops req without last: GAP follows, xfer_cnt is unchanged, rr_ptr=0.
  - Separately, assert rst_n=0 while BUSY: grant=0 the next cycle.
- **Counter wrap:** preload by 65535 accepted beats, then one more accept. xfer_cnt must read 0.
